// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_port_arbiter_pkg
// Brief  : Shared types for the instruction/data SRAM port arbiter: FSM state
//          encoding, grant identifiers and one-hot grant bit positions.
// Rev    : 1.0  initial release
// ============================================================================
package sram_port_arbiter_pkg;

  // Arbiter FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_I0_REQ  = 3'd1,
    ST_I0_WAIT = 3'd2,
    ST_I1_REQ  = 3'd3,
    ST_I1_WAIT = 3'd4,
    ST_D_REQ   = 3'd5,
    ST_D_WAIT  = 3'd6
  } state_t;

  // Identity of the requester that received the most recent grant
  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } gnt_id_t;

  // Bit positions inside the one-hot request/grant vectors
  localparam int c_inst_bit = 0;
  localparam int c_data_bit = 1;

  // True in the states that present a request on the downstream bus
  function automatic logic is_req_state(input state_t s);
    return (s == ST_I0_REQ) || (s == ST_I1_REQ) || (s == ST_D_REQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : sram_port_arbiter_if
// Brief  : Signal bundle for the arbiter: instruction-fetch port, data port
//          and the shared downstream SRAM-like bus.
//          slave  : arbiter view (serves the two requesters, drives the bus)
//          master : environment view (requesters plus downstream memory)
// Rev    : 1.0  initial release
// ============================================================================
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch port (64-bit pair)
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [2*DATA_W-1:0]   inst_rdata;
  // data port
  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;
  // downstream bus
  logic                  bus_req;
  logic                  bus_wr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter_rr2.sv
`default_nettype none
// ============================================================================
// Module : arb_rr2
// Brief  : Two-way round-robin picker. A lone requester always wins; on a
//          simultaneous request the one that did not win last time is chosen.
//          Purely combinational, one-hot grant.
// Rev    : 1.0  initial release
// ============================================================================
module arb_rr2
  import sram_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_id_t    last,
  output logic [1:0] gnt
);

  // Pick the single requester, or alternate away from the previous winner
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt[c_inst_bit] = 1'b1;
      2'b10:   gnt[c_data_bit] = 1'b1;
      2'b11: begin
        if (last == GNT_INST) gnt[c_data_bit] = 1'b1;
        else                  gnt[c_inst_bit] = 1'b1;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sram_port_arbiter
// Brief  : Shares one SRAM-like port between instruction fetch (two 32-bit
//          beats per 64-bit pair) and the data path. One outstanding
//          downstream transaction; round-robin between the requesters.
// Rev    : 1.0  initial release
// ============================================================================
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  sram_port_arbiter_if.slave  port
);

  // Seeding last-grant with the other side makes the preferred side win first
  localparam gnt_id_t          c_last_rst    = DATA_FIRST ? GNT_INST : GNT_DATA;
  localparam logic [ADDR_W-1:0] c_beat_stride = ADDR_W'(DATA_W / 8);

  state_t              r_state;
  state_t              w_state_nxt;
  gnt_id_t             r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_wdata;
  logic [2*DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;
  logic                r_inst_data_ok;
  logic                r_data_data_ok;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_grant_inst;
  logic                w_grant_data;
  logic                w_beat_done;

  // Requests are masked during reset so no accept pulse escapes while resetn is low
  assign w_req[c_inst_bit] = port.inst_req & resetn;
  assign w_req[c_data_bit] = port.data_req & resetn;

  arb_rr2 u_arb (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state, grant and beat-completion decode
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_beat_done  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt[c_data_bit]) begin
          w_grant_data = 1'b1;
          w_state_nxt  = ST_D_REQ;
        end else if (w_gnt[c_inst_bit]) begin
          w_grant_inst = 1'b1;
          w_state_nxt  = ST_I0_REQ;
        end
      end
      ST_I0_REQ: begin
        if (port.bus_addr_ok) begin
          w_beat_done = port.bus_data_ok;
          w_state_nxt = port.bus_data_ok ? ST_I1_REQ : ST_I0_WAIT;
        end
      end
      ST_I0_WAIT: begin
        if (port.bus_data_ok) begin
          w_beat_done = 1'b1;
          w_state_nxt = ST_I1_REQ;
        end
      end
      ST_I1_REQ: begin
        if (port.bus_addr_ok) begin
          w_beat_done = port.bus_data_ok;
          w_state_nxt = port.bus_data_ok ? ST_IDLE : ST_I1_WAIT;
        end
      end
      ST_I1_WAIT: begin
        if (port.bus_data_ok) begin
          w_beat_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_D_REQ: begin
        if (port.bus_addr_ok) begin
          w_beat_done = port.bus_data_ok;
          w_state_nxt = port.bus_data_ok ? ST_IDLE : ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (port.bus_data_ok) begin
          w_beat_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latching on grant, beat-address advance and response capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last         <= c_last_rst;
      r_addr         <= '0;
      r_wr           <= 1'b0;
      r_wstrb        <= '0;
      r_wdata        <= '0;
      r_inst_rdata   <= '0;
      r_data_rdata   <= '0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
    end else begin
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      if (w_grant_inst) begin
        r_addr  <= port.inst_addr;
        r_wr    <= 1'b0;
        r_wstrb <= '0;
        r_wdata <= '0;
        r_last  <= GNT_INST;
      end
      if (w_grant_data) begin
        r_addr  <= port.data_addr;
        r_wr    <= port.data_wr;
        r_wstrb <= port.data_wr ? port.data_wstrb : '0;
        r_wdata <= port.data_wdata;
        r_last  <= GNT_DATA;
      end
      if (w_beat_done) begin
        unique case (r_state)
          ST_I0_REQ, ST_I0_WAIT: begin
            r_inst_rdata[DATA_W-1:0] <= port.bus_rdata;
            r_addr                   <= r_addr + c_beat_stride;
          end
          ST_I1_REQ, ST_I1_WAIT: begin
            r_inst_rdata[2*DATA_W-1:DATA_W] <= port.bus_rdata;
            r_inst_data_ok                  <= 1'b1;
          end
          ST_D_REQ, ST_D_WAIT: begin
            if (!r_wr) r_data_rdata <= port.bus_rdata;
            r_data_data_ok <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign port.inst_addr_ok = w_grant_inst;
  assign port.data_addr_ok = w_grant_data;
  assign port.inst_data_ok = r_inst_data_ok;
  assign port.data_data_ok = r_data_data_ok;
  assign port.inst_rdata   = r_inst_rdata;
  assign port.data_rdata   = r_data_rdata;

  assign port.bus_req      = is_req_state(r_state);
  assign port.bus_wr       = r_wr;
  assign port.bus_wstrb    = r_wstrb;
  assign port.bus_addr     = r_addr;
  assign port.bus_wdata    = r_wdata;

endmodule
`default_nettype wire
